// File: rtl/icache_pkg.sv
// Shared state encoding, derived geometry and PC field helpers for the set-associative icache.
// The helpers return zero-extended 32-bit fields; callers slice them to the configured width.
package icache_pkg;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_REFILL = 1'b1;

  function automatic int tag_width(input int index_w, input int line_w);
    return 32 - index_w - line_w - 2;
  endfunction

  function automatic int words(input int line_w);
    return 1 << line_w;
  endfunction

  function automatic logic [31:0] pc_offset(input logic [31:0] pc, input int line_w);
    return (pc >> 2) & ((32'd1 << line_w) - 32'd1);
  endfunction

  function automatic logic [31:0] pc_index(input logic [31:0] pc, input int index_w, input int line_w);
    return (pc >> (line_w + 2)) & ((32'd1 << index_w) - 32'd1);
  endfunction

  function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int index_w, input int line_w);
    return pc >> (index_w + line_w + 2);
  endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: per-set valid/tag plus line data; combinational lookup, one-cycle write/set/clear.
// No backpressure; the owner sequences writes and gates them with its global enable.
module icache_way
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH = 3,
  parameter int LINE_WIDTH  = 2,
  parameter int TAG_WIDTH   = 27
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [INDEX_WIDTH-1:0] i_rd_index,
  input  logic [LINE_WIDTH-1:0]  i_rd_offset,
  input  logic [TAG_WIDTH-1:0]   i_rd_tag,
  output logic                   o_vld,
  output logic                   o_hit,
  output logic [31:0]            o_rd_word,
  input  logic                   i_wr_en,
  input  logic [INDEX_WIDTH-1:0] i_wr_index,
  input  logic [LINE_WIDTH-1:0]  i_wr_offset,
  input  logic [31:0]            i_wr_word,
  input  logic                   i_set_vld,
  input  logic [TAG_WIDTH-1:0]   i_set_tag,
  input  logic                   i_clr_all
);

  localparam int SETS  = 1 << INDEX_WIDTH;
  localparam int WORDS = words(LINE_WIDTH);

  logic [SETS-1:0]      r_vld;
  logic [TAG_WIDTH-1:0] r_tag  [SETS];
  logic [31:0]          r_data [SETS*WORDS];

  assign o_vld     = r_vld[i_rd_index];
  assign o_hit     = o_vld && (r_tag[i_rd_index] == i_rd_tag);
  assign o_rd_word = r_data[{i_rd_index, i_rd_offset}];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld <= '0;
    end else if (i_clr_all) begin
      r_vld <= '0;
    end else if (i_set_vld) begin
      r_vld[i_wr_index] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; valid bits alone qualify them.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_data[{i_wr_index, i_wr_offset}] <= i_wr_word;
    end
    if (i_set_vld) begin
      r_tag[i_wr_index] <= i_set_tag;
    end
  end

endmodule

// File: rtl/icache_assoc.sv
// Set-associative icache: hit -> have_result 1 cycle later; miss stalls for a full line refill
// (one word per memctrl response) with round-robin victims. ICACHE_PERF_EN adds hit/miss counters.
module icache_assoc
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH = 3,
  parameter int WAY_WIDTH   = 1,
  parameter int LINE_WIDTH  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        to_icache,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic        have_result,
  output logic [31:0] inst,
  output logic        icache_to_memctrl,
  output logic [31:0] address,
  input  logic        memctrl_to_icache,
  input  logic [31:0] inst_in
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int TAG_WIDTH = tag_width(INDEX_WIDTH, LINE_WIDTH);
  localparam int SETS      = 1 << INDEX_WIDTH;
  localparam int WAYS      = 1 << WAY_WIDTH;
  localparam int VW        = (WAY_WIDTH > 0) ? WAY_WIDTH : 1;

  logic [31:0]            w_off_full, w_idx_full, w_tag_full;
  logic [LINE_WIDTH-1:0]  w_off;
  logic [INDEX_WIDTH-1:0] w_idx;
  logic [TAG_WIDTH-1:0]   w_tag;
  logic                   w_unused_bits;

  assign w_off_full    = pc_offset(pc, LINE_WIDTH);
  assign w_idx_full    = pc_index(pc, INDEX_WIDTH, LINE_WIDTH);
  assign w_tag_full    = pc_tag(pc, INDEX_WIDTH, LINE_WIDTH);
  assign w_off         = w_off_full[LINE_WIDTH-1:0];
  assign w_idx         = w_idx_full[INDEX_WIDTH-1:0];
  assign w_tag         = w_tag_full[TAG_WIDTH-1:0];
  assign w_unused_bits = ^{w_off_full[31:LINE_WIDTH], w_idx_full[31:INDEX_WIDTH], w_tag_full[31:TAG_WIDTH]};

  logic [0:0]             r_state;
  logic                   r_have;
  logic [31:0]            r_inst;
  logic                   r_req;
  logic [31:0]            r_addr;
  logic [LINE_WIDTH-1:0]  r_cnt;
  logic [31:0]            r_crit;
  logic [LINE_WIDTH-1:0]  r_req_off;
  logic [INDEX_WIDTH-1:0] r_req_idx;
  logic [TAG_WIDTH-1:0]   r_req_tag;
  logic [VW-1:0]          r_victim;
  logic [VW-1:0]          r_rr [SETS];

  logic [WAYS-1:0] w_vld, w_hit;
  logic [31:0]     w_word [WAYS];
  logic [31:0]     w_hit_word;
  logic            w_any_hit;
  logic [VW-1:0]   w_victim;
  logic            w_wr_en, w_last, w_set_vld, w_clr;
  logic [31:0]     w_crit_next;

  assign w_any_hit   = |w_hit;
  assign w_last      = &r_cnt;
  assign w_wr_en     = rdy && !flush && (r_state == ST_REFILL) && memctrl_to_icache;
  assign w_set_vld   = w_wr_en && w_last;
  assign w_clr       = rdy && flush;
  assign w_crit_next = (r_cnt == r_req_off) ? inst_in : r_crit;

  always_comb begin
    w_hit_word = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (w_hit[i]) w_hit_word = w_hit_word | w_word[i];
    end
  end

  // An empty way always beats the round-robin choice, lowest index first.
  always_comb begin
    w_victim = r_rr[w_idx];
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!w_vld[i]) w_victim = VW'(i);
    end
  end

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    icache_way #(
      .INDEX_WIDTH(INDEX_WIDTH),
      .LINE_WIDTH (LINE_WIDTH),
      .TAG_WIDTH  (TAG_WIDTH)
    ) u_way (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_rd_index (w_idx),
      .i_rd_offset(w_off),
      .i_rd_tag   (w_tag),
      .o_vld      (w_vld[g]),
      .o_hit      (w_hit[g]),
      .o_rd_word  (w_word[g]),
      .i_wr_en    (w_wr_en && (r_victim == VW'(g))),
      .i_wr_index (r_req_idx),
      .i_wr_offset(r_cnt),
      .i_wr_word  (inst_in),
      .i_set_vld  (w_set_vld && (r_victim == VW'(g))),
      .i_set_tag  (r_req_tag),
      .i_clr_all  (w_clr)
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_have    <= 1'b0;
      r_inst    <= '0;
      r_req     <= 1'b0;
      r_addr    <= '0;
      r_cnt     <= '0;
      r_crit    <= '0;
      r_req_off <= '0;
      r_req_idx <= '0;
      r_req_tag <= '0;
      r_victim  <= '0;
      for (int i = 0; i < SETS; i++) r_rr[i] <= '0;
    end else if (rdy) begin
      if (flush) begin
        r_state <= ST_IDLE;
        r_have  <= 1'b0;
        r_req   <= 1'b0;
        for (int i = 0; i < SETS; i++) r_rr[i] <= '0;
      end else if (r_state == ST_IDLE) begin
        r_have <= 1'b0;
        if (to_icache && w_any_hit) begin
          r_have <= 1'b1;
          r_inst <= w_hit_word;
        end else if (to_icache) begin
          r_req_off <= w_off;
          r_req_idx <= w_idx;
          r_req_tag <= w_tag;
          r_victim  <= w_victim;
          r_req     <= 1'b1;
          r_addr    <= {w_tag, w_idx, {(LINE_WIDTH + 2){1'b0}}};
          r_cnt     <= '0;
          r_state   <= ST_REFILL;
        end
      end else if (memctrl_to_icache) begin
        r_cnt  <= r_cnt + LINE_WIDTH'(1);
        r_addr <= r_addr + 32'd4;
        r_crit <= w_crit_next;
        if (w_last) begin
          r_req   <= 1'b0;
          r_have  <= 1'b1;
          r_inst  <= w_crit_next;
          r_state <= ST_IDLE;
          r_rr[r_req_idx] <= (r_rr[r_req_idx] == VW'(WAYS - 1)) ? '0 : r_rr[r_req_idx] + VW'(1);
        end
      end
    end
  end

  assign have_result       = r_have;
  assign inst              = r_inst;
  assign icache_to_memctrl = r_req;
  assign address           = r_addr;

`ifdef ICACHE_PERF_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (rdy && !flush && (r_state == ST_IDLE) && to_icache) begin
      if (w_any_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
      else           r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: doc/icache_assoc.md
Name: icache_assoc

Overview:
Parametrised set-associative instruction cache between the Decoder's fetch request and memctrl. It replaces the direct-mapped, single-word-line icache.
- Multi-word lines refilled one word per memctrl response.
- Configurable associativity with round-robin replacement.
- Flush input for fence.i and pipeline clears.
Hits return in one cycle. Misses stall the Decoder until the line refill completes.

Parameters:
INDEX_WIDTH, 3, log2 of set count (8 sets).
WAY_WIDTH, 1, log2 of ways (0 = direct-mapped, 1 = 2-way, 2 = 4-way).
LINE_WIDTH, 2, log2 of words per line (4 words = 16 bytes).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
rdy  in  1  global enable; low freezes all state.
to_icache  in  1  Decoder fetch request; held until have_result.
pc  in  32  fetch address, word aligned (pc[1:0] ignored).
flush  in  1  invalidate all lines; abort any refill.
have_result  out  1  one-cycle pulse: inst valid for the accepted pc.
inst  out  32  fetched instruction.
icache_to_memctrl  out  1  word read request, level; held until response.
address  out  32  word address of current request.
memctrl_to_icache  in  1  response valid, one cycle per word.
inst_in  in  32  response data.

Behaviour:
- Address split: offset = pc[LINE_WIDTH+1:2]; index = pc[INDEX_WIDTH+LINE_WIDTH+1:LINE_WIDTH+2]; tag = remaining upper bits.
- Reset: all valid bits 0; rr pointers 0; state IDLE; have_result 0; inst 0; icache_to_memctrl 0; address 0. Data and tag arrays are not reset.
- rdy low: no state, array or output changes; have_result holds its value.
- State IDLE, to_icache=1, hit (any way valid with matching tag):
  - next cycle: have_result=1, inst = the hitting way's word [offset].
  - hit-to-result latency is 1 cycle.
- State IDLE, miss:
  - latch pc into req_pc.
  - choose victim: lowest-index invalid way, else rr[index].
  - set icache_to_memctrl=1, address = {line base, offset 0}, word counter = 0.
  - go to REFILL; have_result=0.
- State IDLE, to_icache=0: have_result=0. A response arriving in IDLE is ignored.
- State REFILL, on each memctrl_to_icache:
  - write inst_in into victim word [counter].
  - if counter == req_pc offset, capture inst_in into a critical-word register.
  - counter+1; address += 4; icache_to_memctrl stays high.
- Last word (counter == 2^LINE_WIDTH-1) with response:
  - same cycle: write that word; set tag and valid for the victim; advance rr[index] (wrap mod ways); drop icache_to_memctrl.
  - next cycle: have_result=1, inst = critical word. If the critical word is the last word, use inst_in directly. Return to IDLE.
- pc/to_icache changes during REFILL are ignored. The result always corresponds to req_pc.
- Miss latency: 1 + 2^LINE_WIDTH responses + 1 cycle to have_result.
- flush (when rdy):
  - clears all valid bits and rr pointers in the same cycle.
  - in REFILL: icache_to_memctrl drops next cycle, the victim is left invalid, state returns to IDLE, have_result=0.
  - in IDLE: any hit in that cycle is suppressed (have_result=0).
  - flush has priority over everything except rst.
- Address wrap: line base + offset wraps modulo 2^32. No special case.
- Only one outstanding memctrl request. memctrl abandons a request when icache_to_memctrl falls.

Optional Feature:
ICACHE_PERF_EN: when defined, adds two ports:
- hit_cnt out 32, increments once per IDLE hit that produces have_result.
- miss_cnt out 32, increments once per IDLE→REFILL transition.
Both reset to 0 and are unaffected by flush. They wrap at 2^32 and freeze when rdy is low. When undefined, neither the ports nor the counters exist, and behaviour is otherwise identical.

Decomposition:
- Package icache_pkg: state encoding (IDLE, REFILL), derived widths TAG_WIDTH = 32-INDEX_WIDTH-LINE_WIDTH-2, WORDS = 1<<LINE_WIDTH, and field-extract helpers for offset/index/tag.
- Sub-module icache_way: one way's valid/tag/data arrays. It provides a combinational tag compare and read word, plus write-word, set-valid and clear-all ports. It is instantiated 2^WAY_WIDTH times by icache_assoc, which owns the FSM, replacement and memctrl handshake.

Test Plan:
- Cold miss, defaults, pc=0x100: icache_to_memctrl=1 with address 0x100, 0x104, 0x108, 0x10C across 4 responses (0xA0..0xA3); have_result=1 with inst=0xA0; a refetch of pc=0x108 hits next cycle with inst=0xA2.
- Critical word last: pc=0x20C cold → 4 responses; inst = 4th response value, no extra cycle.
- Replacement, 2-way: fill lines 0x000, 0x080, 0x100 (same index 0) → 0x000 evicted. Refetch 0x080 hits; refetch 0x000 misses.
- flush mid-refill after 2 of 4 responses: icache_to_memctrl=0 next cycle, no have_result. Refetch of the same pc re-misses, starting at word 0.
- rdy=0 for 3 cycles during REFILL with a response pulse held: no counter advance and outputs frozen. Resumes correctly when rdy=1.
- ICACHE_PERF_EN defined: sequence miss, hit, hit, flush, miss → miss_cnt=2, hit_cnt=2.
